// File: rtl/morse_pkg.sv
// morse_pkg: letter-code constants and FSM state type shared by the Morse
// decoder chain (alphabet decoder, message buffer, VGA text renderer).
//   Codes 0..25 = A..Z, 26 = space, 27..30 invalid, 31 = blank.
package morse_pkg;

  localparam int LETTER_W = 5;

  localparam logic [LETTER_W-1:0] LTR_A     = 5'd0;
  localparam logic [LETTER_W-1:0] LTR_Z     = 5'd25;
  localparam logic [LETTER_W-1:0] LTR_SPACE = 5'd26;
  localparam logic [LETTER_W-1:0] LTR_BLANK = 5'd31;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } msg_state_t;

  // Codes 27..30 carry no meaning and are dropped by consumers.
  function automatic logic ltr_is_valid(input logic [LETTER_W-1:0] code);
    return (code <= LTR_SPACE) || (code == LTR_BLANK);
  endfunction

endpackage

// File: rtl/edge_rise.sv
// edge_rise: single-bit rising-edge detector.
//   Clk     in  system clock
//   RESET_N in  asynchronous active-low reset (history cleared to 0)
//   d_i     in  level input
//   rise_o  out combinational pulse, high while d_i=1 and previous sample=0
module edge_rise (
  input  logic Clk,
  input  logic RESET_N,
  input  logic d_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) hist_q <= 1'b0;
    else          hist_q <= d_i;
  end

  assign rise_o = d_i & ~hist_q;

endmodule

// File: rtl/morse_msg_buffer.sv
// morse_msg_buffer: circular line buffer of decoded letters between the
// alphabet decoder and the VGA text renderer.
//   Clk, RESET_N        clock, asynchronous active-low reset
//   LETTER, STROBE      letter code, captured on STROBE rising edge
//   BKSP, CLEAR         rising edge removes newest letter / empties buffer
//   RD_ADDR, RD_DATA    logical read port (0 = oldest), 1-cycle latency
//   COUNT, EMPTY, FULL  occupancy
//   BUSY                blank-sweep in progress (after reset or CLEAR)
//   OVERFLOW            sticky, a letter arrived while full
//   LAST_LETTER         newest letter held, 31 when empty
//   NEW_LETTER          one-cycle pulse after each accepted letter
// Build option: MORSE_MSG_SCROLL_EN -- when defined, a letter arriving while
// full overwrites the oldest one (line scrolls); otherwise it is dropped.
module morse_msg_buffer
  import morse_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                Clk,
  input  logic                RESET_N,
  input  logic [LETTER_W-1:0] LETTER,
  input  logic                STROBE,
  input  logic                BKSP,
  input  logic                CLEAR,
  input  logic [AW-1:0]       RD_ADDR,
  output logic [LETTER_W-1:0] RD_DATA,
  output logic [AW:0]         COUNT,
  output logic                EMPTY,
  output logic                FULL,
  output logic                BUSY,
  output logic                OVERFLOW,
  output logic [LETTER_W-1:0] LAST_LETTER,
  output logic                NEW_LETTER
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

  msg_state_t          state_q, state_d;
  logic [AW-1:0]       sweep_q, sweep_d;
  logic [AW-1:0]       head_q, head_d;
  logic [AW:0]         count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [LETTER_W-1:0] last_q, last_d;
  logic                new_q, new_d;
  logic [LETTER_W-1:0] rd_data_q;

  logic [LETTER_W-1:0] mem_q [DEPTH];
  logic                we;
  logic [AW-1:0]       waddr;
  logic [LETTER_W-1:0] wdata;

  logic stb_rise, bksp_rise, clr_rise;
  logic full, busy;
  logic [AW-1:0] wr_idx, newest_idx, prev_idx, rd_idx;

  edge_rise u_stb_edge  (.Clk(Clk), .RESET_N(RESET_N), .d_i(STROBE), .rise_o(stb_rise));
  edge_rise u_bksp_edge (.Clk(Clk), .RESET_N(RESET_N), .d_i(BKSP),   .rise_o(bksp_rise));
  edge_rise u_clr_edge  (.Clk(Clk), .RESET_N(RESET_N), .d_i(CLEAR),  .rise_o(clr_rise));

  assign full = (count_q == DEPTH_C);
  assign busy = (state_q == SWEEP);

  // When full, COUNT's low bits are zero so the write index lands on head,
  // which is exactly the slot a scrolling overwrite needs.
  assign wr_idx     = head_q + count_q[AW-1:0];
  assign newest_idx = wr_idx - AW'(1);
  assign prev_idx   = wr_idx - AW'(2);
  assign rd_idx     = head_q + RD_ADDR;

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    head_d  = head_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    last_d  = last_q;
    new_d   = 1'b0;
    we      = 1'b0;
    waddr   = sweep_q;
    wdata   = LTR_BLANK;

    case (state_q)
      SWEEP: begin
        we      = 1'b1;
        head_d  = '0;
        count_d = '0;
        ovf_d   = 1'b0;
        last_d  = LTR_BLANK;
        if (clr_rise) begin
          sweep_d = '0;
        end else if (sweep_q == LAST_IX) begin
          sweep_d = '0;
          state_d = IDLE;
        end else begin
          sweep_d = sweep_q + AW'(1);
        end
      end

      IDLE: begin
        if (clr_rise) begin
          state_d = SWEEP;
          sweep_d = '0;
          head_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
          last_d  = LTR_BLANK;
        end else if (stb_rise && ltr_is_valid(LETTER)) begin
          // A same-cycle BKSP edge is deliberately swallowed here.
          if (!full) begin
            we      = 1'b1;
            waddr   = wr_idx;
            wdata   = LETTER;
            count_d = count_q + 1'b1;
            last_d  = LETTER;
            new_d   = 1'b1;
          end else begin
`ifdef MORSE_MSG_SCROLL_EN
            we     = 1'b1;
            waddr  = head_q;
            wdata  = LETTER;
            head_d = head_q + AW'(1);
            last_d = LETTER;
            new_d  = 1'b1;
            ovf_d  = 1'b1;
`else
            ovf_d  = 1'b1;
`endif
          end
        end else if (bksp_rise && (count_q != '0)) begin
          we      = 1'b1;
          waddr   = newest_idx;
          wdata   = LTR_BLANK;
          count_d = count_q - 1'b1;
          last_d  = (count_q == (AW+1)'(1)) ? LTR_BLANK : mem_q[prev_idx];
        end
      end

      default: state_d = SWEEP;
    endcase
  end

  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= SWEEP;
      sweep_q   <= '0;
      head_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      last_q    <= LTR_BLANK;
      new_q     <= 1'b0;
      rd_data_q <= LTR_BLANK;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      head_q  <= head_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      last_q  <= last_d;
      new_q   <= new_d;
      // Read uses pre-edge state, so a write at this edge shows next cycle.
      if (busy || ({1'b0, RD_ADDR} >= count_q)) rd_data_q <= LTR_BLANK;
      else                                     rd_data_q <= mem_q[rd_idx];
    end
  end

  // Storage has no reset; the sweep blanks it and reads are masked meanwhile.
  always_ff @(posedge Clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign RD_DATA     = rd_data_q;
  assign COUNT       = count_q;
  assign EMPTY       = (count_q == '0);
  assign FULL        = full;
  assign BUSY        = busy;
  assign OVERFLOW    = ovf_q;
  assign LAST_LETTER = last_q;
  assign NEW_LETTER  = new_q;

endmodule

// File: tb/tb_morse_msg_buffer.sv
module tb_morse_msg_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          Clk = 1'b0;
  logic          RESET_N = 1'b1;
  logic [4:0]    LETTER = '0;
  logic          STROBE = 1'b0;
  logic          BKSP = 1'b0;
  logic          CLEAR = 1'b0;
  logic [AW-1:0] RD_ADDR = '0;
  logic [4:0]    RD_DATA;
  logic [AW:0]   COUNT;
  logic          EMPTY, FULL, BUSY, OVERFLOW, NEW_LETTER;
  logic [4:0]    LAST_LETTER;

  int checks = 0;
  int errors = 0;

  // Reference model: the line as an ordered queue, oldest at index 0.
  int   line[$];
  int   m_last = 31;
  logic m_ovf  = 1'b0;

  morse_msg_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clk(Clk), .RESET_N(RESET_N), .LETTER(LETTER), .STROBE(STROBE),
    .BKSP(BKSP), .CLEAR(CLEAR), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL), .BUSY(BUSY),
    .OVERFLOW(OVERFLOW), .LAST_LETTER(LAST_LETTER), .NEW_LETTER(NEW_LETTER)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic bit code_ok(input int code);
    return (code <= 26) || (code == 31);
  endfunction

  function automatic int exp_rd(input int a);
    return (a < line.size()) ? line[a] : 31;
  endfunction

  task automatic m_clear();
    line.delete();
    m_last = 31;
    m_ovf  = 1'b0;
  endtask

  task automatic m_strobe(input int code, output bit exp_new);
    exp_new = 1'b0;
    if (!code_ok(code)) return;
    if (line.size() < DEPTH) begin
      line.push_back(code);
      m_last  = code;
      exp_new = 1'b1;
    end else begin
      m_ovf = 1'b1;
`ifdef MORSE_MSG_SCROLL_EN
      void'(line.pop_front());
      line.push_back(code);
      m_last  = code;
      exp_new = 1'b1;
`endif
    end
  endtask

  task automatic m_bksp();
    if (line.size() == 0) return;
    void'(line.pop_back());
    m_last = (line.size() == 0) ? 31 : line[line.size()-1];
  endtask

  // Stimulus primitives (no checking inside).
  task automatic strobe_op(input int code, input logic bk, output logic saw_new);
    LETTER = 5'(code);
    STROBE = 1'b1;
    BKSP   = bk;
    tick();
    saw_new = NEW_LETTER;
    STROBE = 1'b0;
    BKSP   = 1'b0;
    tick();
  endtask

  task automatic bksp_op();
    BKSP = 1'b1;
    tick();
    BKSP = 1'b0;
    tick();
  endtask

  task automatic read_pos(input int a, output logic [4:0] d);
    RD_ADDR = AW'(a);
    tick();
    d = RD_DATA;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic clear_op(output int n);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    wait_idle(n);
    m_clear();
  endtask

  task automatic release_reset(output int n);
    @(posedge Clk);
    #1;
    RESET_N = 1'b1;
    m_clear();
    wait_idle(n);
  endtask

  task automatic test_reset();
    int n;
    logic [4:0] d;
    #2 RESET_N = 1'b0;
    tick();
    checks++; if (COUNT !== 0)      begin errors++; $display("FAIL reset_count got %0d want 0", COUNT); end
    checks++; if (EMPTY !== 1'b1)   begin errors++; $display("FAIL reset_empty got %0b want 1", EMPTY); end
    checks++; if (FULL !== 1'b0)    begin errors++; $display("FAIL reset_full got %0b want 0", FULL); end
    checks++; if (BUSY !== 1'b1)    begin errors++; $display("FAIL reset_busy got %0b want 1", BUSY); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", OVERFLOW); end
    checks++; if (LAST_LETTER !== 5'd31) begin errors++; $display("FAIL reset_last got %0d want 31", LAST_LETTER); end
    checks++; if (NEW_LETTER !== 1'b0) begin errors++; $display("FAIL reset_new got %0b want 0", NEW_LETTER); end
    checks++; if (RD_DATA !== 5'd31) begin errors++; $display("FAIL reset_rd got %0d want 31", RD_DATA); end
    release_reset(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL reset_sweep_len got %0d want 16", n); end
    for (int a = 0; a < DEPTH; a++) begin
      read_pos(a, d);
      checks++; if (d !== 5'd31) begin errors++; $display("FAIL reset_read[%0d] got %0d want 31", a, d); end
    end
  endtask

  task automatic test_hello();
    int codes[5] = '{7, 4, 11, 11, 14};
    int pulses, n;
    bit en;
    logic sn;
    logic [4:0] d;
    clear_op(n);
    pulses = 0;
    foreach (codes[i]) begin
      strobe_op(codes[i], 1'b0, sn);
      m_strobe(codes[i], en);
      if (sn === 1'b1) pulses++;
    end
    checks++; if (pulses !== 5) begin errors++; $display("FAIL hello_pulses got %0d want 5", pulses); end
    checks++; if (COUNT !== 5) begin errors++; $display("FAIL hello_count got %0d want 5", COUNT); end
    checks++; if (LAST_LETTER !== 5'd14) begin errors++; $display("FAIL hello_last got %0d want 14", LAST_LETTER); end
    for (int a = 0; a <= 5; a++) begin
      read_pos(a, d);
      checks++; if (d !== 5'(exp_rd(a))) begin errors++; $display("FAIL hello_read[%0d] got %0d want %0d", a, d, exp_rd(a)); end
    end
    // A held STROBE level must act once only.
    LETTER = 5'd0;
    STROBE = 1'b1;
    pulses = 0;
    repeat (10) begin
      tick();
      if (NEW_LETTER === 1'b1) pulses++;
    end
    STROBE = 1'b0;
    tick();
    m_strobe(0, en);
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_strobe_pulses got %0d want 1", pulses); end
    checks++; if (COUNT !== 6) begin errors++; $display("FAIL held_strobe_count got %0d want 6", COUNT); end
  endtask

  task automatic test_bksp();
    int codes[5] = '{7, 4, 11, 11, 14};
    int n;
    bit en;
    logic sn;
    logic [4:0] d;
    clear_op(n);
    foreach (codes[i]) begin
      strobe_op(codes[i], 1'b0, sn);
      m_strobe(codes[i], en);
    end
    bksp_op();
    m_bksp();
    checks++; if (COUNT !== 4) begin errors++; $display("FAIL bksp_count got %0d want 4", COUNT); end
    checks++; if (LAST_LETTER !== 5'd11) begin errors++; $display("FAIL bksp_last got %0d want 11", LAST_LETTER); end
    read_pos(4, d);
    checks++; if (d !== 5'd31) begin errors++; $display("FAIL bksp_read4 got %0d want 31", d); end
    repeat (5) begin
      bksp_op();
      m_bksp();
    end
    checks++; if (COUNT !== 0) begin errors++; $display("FAIL bksp_underflow_count got %0d want 0", COUNT); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL bksp_empty got %0b want 1", EMPTY); end
    checks++; if (LAST_LETTER !== 5'd31) begin errors++; $display("FAIL bksp_empty_last got %0d want 31", LAST_LETTER); end
  endtask

  task automatic test_same_cycle();
    int n;
    bit en;
    logic sn;
    clear_op(n);
    strobe_op(1, 1'b0, sn); m_strobe(1, en);
    strobe_op(2, 1'b0, sn); m_strobe(2, en);
    strobe_op(5, 1'b1, sn); m_strobe(5, en);
    checks++; if (COUNT !== 3) begin errors++; $display("FAIL same_cycle_count got %0d want 3", COUNT); end
    checks++; if (LAST_LETTER !== 5'd5) begin errors++; $display("FAIL same_cycle_last got %0d want 5", LAST_LETTER); end
    strobe_op(28, 1'b0, sn); m_strobe(28, en);
    checks++; if (COUNT !== 3) begin errors++; $display("FAIL invalid_code_count got %0d want 3", COUNT); end
    checks++; if (sn !== 1'b0) begin errors++; $display("FAIL invalid_code_new got %0b want 0", sn); end
  endtask

  task automatic test_overflow();
    int n;
    int first[16];
    bit en;
    logic sn;
    logic [4:0] d;
    clear_op(n);
    for (int i = 0; i < DEPTH; i++) begin
      first[i] = $urandom_range(0, 26);
      strobe_op(first[i], 1'b0, sn);
      m_strobe(first[i], en);
    end
    checks++; if (FULL !== 1'b1) begin errors++; $display("FAIL ovf_full got %0b want 1", FULL); end
    strobe_op(3, 1'b0, sn);
    m_strobe(3, en);
    checks++; if (COUNT !== 16) begin errors++; $display("FAIL ovf_count got %0d want 16", COUNT); end
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", OVERFLOW); end
    checks++; if (sn !== logic'(en)) begin errors++; $display("FAIL ovf_new got %0b want %0b", sn, en); end
    checks++; if (LAST_LETTER !== 5'(m_last)) begin errors++; $display("FAIL ovf_last got %0d want %0d", LAST_LETTER, m_last); end
`ifdef MORSE_MSG_SCROLL_EN
    read_pos(0, d);
    checks++; if (d !== 5'(first[1])) begin errors++; $display("FAIL scroll_rd0 got %0d want %0d", d, first[1]); end
    read_pos(15, d);
    checks++; if (d !== 5'd3) begin errors++; $display("FAIL scroll_rd15 got %0d want 3", d); end
`endif
    for (int a = 0; a < DEPTH; a++) begin
      read_pos(a, d);
      checks++; if (d !== 5'(exp_rd(a))) begin errors++; $display("FAIL ovf_read[%0d] got %0d want %0d", a, d, exp_rd(a)); end
    end
  endtask

  task automatic test_random();
    int n, op, code;
    bit en;
    logic sn;
    logic [4:0] d;
    clear_op(n);
    for (int k = 0; k < 250; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 4 || op == 7) begin
        code = (op == 7) ? $urandom_range(0, 26) : $urandom_range(0, 30);
        strobe_op(code, logic'(op == 7), sn);
        m_strobe(code, en);
        checks++; if (sn !== logic'(en)) begin errors++; $display("FAIL rnd_new[%0d] got %0b want %0b", k, sn, en); end
      end else if (op <= 6) begin
        bksp_op();
        m_bksp();
      end else begin
        code = $urandom_range(0, DEPTH - 1);
        read_pos(code, d);
        checks++; if (d !== 5'(exp_rd(code))) begin errors++; $display("FAIL rnd_read[%0d] got %0d want %0d", k, d, exp_rd(code)); end
      end
      checks++; if (COUNT !== (AW+1)'(line.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", k, COUNT, line.size()); end
      checks++; if (LAST_LETTER !== 5'(m_last)) begin errors++; $display("FAIL rnd_last[%0d] got %0d want %0d", k, LAST_LETTER, m_last); end
      checks++; if (OVERFLOW !== m_ovf) begin errors++; $display("FAIL rnd_ovf[%0d] got %0b want %0b", k, OVERFLOW, m_ovf); end
      checks++; if ({EMPTY, FULL} !== {logic'(line.size() == 0), logic'(line.size() == DEPTH)}) begin
        errors++; $display("FAIL rnd_flags[%0d] got %0b%0b want %0b%0b", k, EMPTY, FULL, line.size() == 0, line.size() == DEPTH);
      end
    end
  endtask

  task automatic test_clear();
    int n;
    bit en;
    logic sn;
    logic [4:0] d;
    clear_op(n);
    for (int i = 0; i < DEPTH + 1; i++) begin
      strobe_op(i % 27, 1'b0, sn);
      m_strobe(i % 27, en);
    end
    repeat (7) begin
      bksp_op();
      m_bksp();
    end
    checks++; if (COUNT !== 9) begin errors++; $display("FAIL clr_pre_count got %0d want 9", COUNT); end
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf got %0b want 1", OVERFLOW); end
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    n = 0;
    LETTER = 5'd9;
    while (BUSY === 1'b1 && n < 100) begin
      STROBE = ~STROBE;
      tick();
      n++;
    end
    STROBE = 1'b0;
    tick();
    m_clear();
    checks++; if (n !== 16) begin errors++; $display("FAIL clr_sweep_len got %0d want 16", n); end
    checks++; if (COUNT !== 0) begin errors++; $display("FAIL clr_count got %0d want 0", COUNT); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0b want 0", OVERFLOW); end
    checks++; if (LAST_LETTER !== 5'd31) begin errors++; $display("FAIL clr_last got %0d want 31", LAST_LETTER); end
    read_pos(0, d);
    checks++; if (d !== 5'd31) begin errors++; $display("FAIL clr_read0 got %0d want 31", d); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    bit en;
    logic sn;
    clear_op(n);
    strobe_op(12, 1'b0, sn); m_strobe(12, en);
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    repeat (6) tick();
    #2 RESET_N = 1'b0;
    #1;
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL midrst_busy got %0b want 1", BUSY); end
    checks++; if (RD_DATA !== 5'd31) begin errors++; $display("FAIL midrst_rd got %0d want 31", RD_DATA); end
    release_reset(n);
    checks++; if (n !== 16) begin errors++; $display("FAIL midrst_sweep_len got %0d want 16", n); end
    strobe_op(20, 1'b0, sn); m_strobe(20, en);
    checks++; if (COUNT !== 1) begin errors++; $display("FAIL midrst_after_count got %0d want 1", COUNT); end
    checks++; if (sn !== 1'b1) begin errors++; $display("FAIL midrst_after_new got %0b want 1", sn); end
  endtask

  initial begin
    test_reset();
    test_hello();
    test_bksp();
    test_same_cycle();
    test_overflow();
    test_random();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_msg_buffer.md
# morse_msg_buffer

Message buffer sitting directly downstream of the letter decoder (alphabet) and upstream of the VGA text renderer. Captures each decoded 5-bit letter on the decoder's STROBE, in the Clk domain, and holds the last DEPTH letters as an ordered line. The renderer reads the line by logical position through a registered read port. Also provides backspace, clear and status flags.

## Interface
- DEPTH, 16: letter slots; power of two, 4..64
- AW, 4: log2(DEPTH)
- Clk  in  1  system clock; all logic on posedge
- RESET_N  in  1  asynchronous, active-low reset
- LETTER  in  5  decoded letter code; valid when STROBE rises
- STROBE  in  1  decoder strobe; level signal, rising edge = new letter
- BKSP  in  1  backspace request; rising edge removes newest letter
- CLEAR  in  1  clear request; rising edge empties buffer
- RD_ADDR  in  AW  logical position, 0 = oldest
- RD_DATA  out  5  letter at RD_ADDR, 1-cycle latency; 31 if position empty
- COUNT  out  AW+1  letters held, 0..DEPTH
- EMPTY / FULL  out  1  COUNT==0 / COUNT==DEPTH
- BUSY  out  1  clear sweep in progress
- OVERFLOW  out  1  sticky; letter dropped (or oldest discarded) because full
- LAST_LETTER  out  5  newest accepted letter; 31 when empty
- NEW_LETTER  out  1  one-cycle pulse after each accepted letter

## Operation
- Codes: 0..25 = A..Z, 26 = space, 27..30 invalid, 31 = blank. Invalid codes are ignored silently, with no state change.
- STROBE, BKSP and CLEAR each go through a rising-edge detector. A held level acts once.
- Circular storage: head = physical index of the oldest letter. Write index = (head+COUNT) mod DEPTH. Read index = (head+RD_ADDR) mod DEPTH. AW-bit wrap arithmetic.
- FSM states:
  - SWEEP: entered on reset release and on a CLEAR edge. Writes 31 to slots 0..DEPTH-1, one per cycle. head=0, COUNT=0, OVERFLOW=0. BUSY=1. Goes to IDLE after slot DEPTH-1 is written.
  - IDLE: BUSY=0. Accepts events, with priority CLEAR > STROBE > BKSP.
- STROBE accept in IDLE: slot[write index]=LETTER, COUNT+1, LAST_LETTER=LETTER, NEW_LETTER pulses.
- BKSP in IDLE with COUNT>0: COUNT-1, slot becomes 31, LAST_LETTER = previous newest letter (31 if COUNT reaches 0). BKSP with COUNT=0 is ignored.
- Events during SWEEP: STROBE and BKSP edges are discarded. A CLEAR edge restarts the sweep at slot 0.
- STROBE and BKSP edges in the same cycle: the letter is accepted, and that BKSP edge is consumed and lost.
- RD_DATA: registered read of the slot. Returns 31 when RD_ADDR >= COUNT or BUSY=1.

## Timing
- Reset values: COUNT=0, EMPTY=1, FULL=0, BUSY=1, OVERFLOW=0, LAST_LETTER=31, NEW_LETTER=0, RD_DATA=31. Internal: head=0, sweep index=0, edge-detector history=0.
- Sweep lasts exactly DEPTH cycles after reset release or a CLEAR edge. BUSY falls on the following edge.
- Letter accept:
  - STROBE sampled high at edge n, having been low at edge n-1.
  - Slot, COUNT, FULL/EMPTY and LAST_LETTER update at edge n.
  - NEW_LETTER is high from edge n to edge n+1.
- Read latency: RD_ADDR sampled at edge n; RD_DATA valid after edge n. Any write at edge n is visible at edge n+1.
- Reset assertion mid-sweep or mid-operation clears all state immediately, asynchronously.

## Configuration
- MORSE_MSG_SCROLL_EN defined: STROBE accept when FULL overwrites the oldest slot. head+1 (wraps), COUNT stays DEPTH, OVERFLOW set, NEW_LETTER pulses. The display scrolls.
- Not defined: STROBE accept when FULL drops the letter. OVERFLOW set; no slot, head, COUNT or LAST_LETTER change; no NEW_LETTER.

## Structure
- Shared package morse_pkg holds:
  - LETTER_W=5
  - LTR_A=0, LTR_Z=25, LTR_SPACE=26, LTR_BLANK=31
  - msg_state_t {SWEEP, IDLE}
- These constants are also used by the alphabet decoder and the VGA renderer.
- One sub-module: edge_rise (1-bit, Clk/RESET_N, registered history, combinational pulse), instantiated three times.

## Test plan
- Reset release, DEPTH=16: BUSY=1 for exactly 16 cycles, then 0. COUNT=0; RD_DATA=31 for every RD_ADDR.
- Strobe letters 7,4,11,11,14 (HELLO): COUNT=5, LAST_LETTER=14, RD_ADDR 0..4 reads 7,4,11,11,14, RD_ADDR 5 reads 31. Five NEW_LETTER pulses. STROBE held high 10 cycles counts once.
- Fill 16, then strobe letter 3:
  - With the macro: COUNT=16, RD_ADDR 0 = second letter, RD_ADDR 15 = 3, OVERFLOW=1.
  - Without the macro: contents unchanged, OVERFLOW=1, no NEW_LETTER.
- BKSP after HELLO: COUNT=4, LAST_LETTER=11, RD_ADDR 4 reads 31. Five more BKSP edges: COUNT=0, LAST_LETTER=31, no underflow.
- STROBE and BKSP edges in the same cycle with COUNT=2: COUNT=3. Letter code 28: ignored, COUNT unchanged.
- CLEAR edge with COUNT=9: BUSY=1 for 16 cycles, strobes during the sweep are ignored, then COUNT=0 and OVERFLOW=0. Reset asserted mid-sweep restarts the sweep from slot 0.
